width_8to16_arb: RTL and testbench

- Two-requester arbiter/sequencer that shares one 8-to-16 packing datapath between two independent byte streams.
- Grants one channel for exactly one byte pair at a time, with round-robin fairness.
- Packs the pair as {first byte, second byte} into a 16-bit word.
- Presents the word on a valid/ready output port tagged with the source channel. It sits between two byte producers and one 16-bit consumer.

---
 rtl/width_8to16_arb.sv | 141 ++++++++++++++
 tb/tb_width_8to16_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/width_8to16_arb.sv
// Round-robin arbiter that packs byte pairs from two channels into tagged 16-bit words.
// Word valid 1 cycle after the second-byte handshake; a blocked output stalls the second byte without aging the gap timer.
module width_8to16_arb #(
  parameter int unsigned GAP_MAX = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in0,
  input  logic [7:0]  data_in0,
  output logic        ready_in0,
  input  logic        valid_in1,
  input  logic [7:0]  data_in1,
  output logic        ready_in1,
  output logic        valid_out,
  output logic [15:0] data_out,
  output logic        ch_out,
  input  logic        out_ready,
  output logic        drop_err,
  output logic        drop_ch
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [7:0]         byte_hi_q, byte_hi_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               valid_out_q, valid_out_d;
  logic [15:0]        data_out_q, data_out_d;
  logic               ch_out_q, ch_out_d;
  logic               drop_err_q, drop_err_d;
  logic               drop_ch_q, drop_ch_d;

  logic               gnt_vld;
  logic [7:0]         gnt_dat;
  logic               out_free;

  assign gnt_vld  = grant_q ? valid_in1 : valid_in0;
  assign gnt_dat  = grant_q ? data_in1 : data_in0;
  assign out_free = !valid_out_q || out_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_hi_d    = byte_hi_q;
    gap_cnt_d    = gap_cnt_q;
    valid_out_d  = valid_out_q;
    data_out_d   = data_out_q;
    ch_out_d     = ch_out_q;
    drop_err_d   = 1'b0;
    drop_ch_d    = 1'b0;
    ready_in0    = 1'b0;
    ready_in1    = 1'b0;

    if (valid_out_q && out_ready) valid_out_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in0 && valid_in1) begin
          grant_d = ~last_grant_q;
          state_d = HI;
        end else if (valid_in0) begin
          grant_d = 1'b0;
          state_d = HI;
        end else if (valid_in1) begin
          grant_d = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        ready_in0 = !grant_q;
        ready_in1 = grant_q;
        if (gnt_vld) begin
          byte_hi_d = gnt_dat;
          gap_cnt_d = '0;
          state_d   = LO;
        end else begin
          // Withdrawn request: leave last_grant alone so either side may win next.
          state_d = IDLE;
        end
      end
      LO: begin
        ready_in0 = !grant_q && out_free;
        ready_in1 = grant_q && out_free;
        if (gnt_vld && out_free) begin
          data_out_d   = {byte_hi_q, gnt_dat};
          ch_out_d     = grant_q;
          valid_out_d  = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (!gnt_vld) begin
          if (gap_cnt_q == CNT_W'(GAP_MAX)) begin
            drop_err_d   = 1'b1;
            drop_ch_d    = grant_q;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      byte_hi_q    <= '0;
      gap_cnt_q    <= '0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      ch_out_q     <= 1'b0;
      drop_err_q   <= 1'b0;
      drop_ch_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_hi_q    <= byte_hi_d;
      gap_cnt_q    <= gap_cnt_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      ch_out_q     <= ch_out_d;
      drop_err_q   <= drop_err_d;
      drop_ch_q    <= drop_ch_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign ch_out    = ch_out_q;
  assign drop_err  = drop_err_q;
  assign drop_ch   = drop_ch_q;

endmodule

// File: tb/tb_width_8to16_arb.sv
// Directed bench for width_8to16_arb: single stream, backpressure, contention, timeout, reset, withdrawal.
module tb_width_8to16_arb;

  logic        clk;
  logic        rst;
  logic        valid_in0, valid_in1;
  logic [7:0]  data_in0, data_in1;
  logic        ready_in0, ready_in1;
  logic        valid_out;
  logic [15:0] data_out;
  logic        ch_out;
  logic        out_ready;
  logic        drop_err, drop_ch;

  int n_checks = 0;
  int n_pass   = 0;

  width_8to16_arb #(.GAP_MAX(15), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in0 (valid_in0),
    .data_in0  (data_in0),
    .ready_in0 (ready_in0),
    .valid_in1 (valid_in1),
    .data_in1  (data_in1),
    .ready_in1 (ready_in1),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ch_out    (ch_out),
    .out_ready (out_ready),
    .drop_err  (drop_err),
    .drop_ch   (drop_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one uncontested pair from IDLE with the output free; returns with the word visible.
  task automatic pair(input logic ch, input logic [7:0] b0, input logic [7:0] b1);
    if (ch) begin valid_in1 = 1'b1; data_in1 = b0; end
    else    begin valid_in0 = 1'b1; data_in0 = b0; end
    tick();
    tick();
    if (ch) data_in1 = b1; else data_in0 = b1;
    tick();
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
  endtask

  logic [16:0] words [0:7];
  int          n_words;
  logic        hs0, hs1, i0, i1;

  initial begin
    rst = 1'b1; valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = 8'h00; data_in1 = 8'h00; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ch_out", ch_out, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_drop_ch", drop_ch, 0);
    chk("rst_ready0", ready_in0, 0);
    chk("rst_ready1", ready_in1, 0);

    // Single stream on ch0
    valid_in0 = 1'b1; data_in0 = 8'hA5;
    chk("idle_ready0", ready_in0, 0);
    tick();
    chk("hi_ready0", ready_in0, 1);
    chk("hi_ready1", ready_in1, 0);
    tick();
    data_in0 = 8'h3C;
    #1;
    chk("lo_ready0", ready_in0, 1);
    chk("lo_valid_out_pre", valid_out, 0);
    tick();
    valid_in0 = 1'b0;
    chk("s1_valid", valid_out, 1);
    chk("s1_data", data_out, 16'hA53C);
    chk("s1_ch", ch_out, 0);
    pair(1'b0, 8'h01, 8'h02);
    chk("s2_valid", valid_out, 1);
    chk("s2_data", data_out, 16'h0102);
    chk("s2_ch", ch_out, 0);
    tick();
    chk("s2_consumed", valid_out, 0);

    // Backpressure on ch1
    out_ready = 1'b0;
    pair(1'b1, 8'hBE, 8'hEF);
    chk("bp_valid", valid_out, 1);
    chk("bp_data", data_out, 16'hBEEF);
    chk("bp_ch", ch_out, 1);
    valid_in1 = 1'b1; data_in1 = 8'hCA;
    tick();
    chk("bp_hi_ready1", ready_in1, 1);
    tick();
    data_in1 = 8'hFE;
    #1;
    chk("bp_lo_blocked", ready_in1, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_hold_ready1", ready_in1, 0);
      chk("bp_hold_data", data_out, 16'hBEEF);
      chk("bp_no_drop", drop_err, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready1", ready_in1, 1);
    tick();
    out_ready = 1'b0;
    valid_in1 = 1'b0;
    chk("bp_swap_valid", valid_out, 1);
    chk("bp_swap_data", data_out, 16'hCAFE);
    chk("bp_swap_ch", ch_out, 1);
    tick();
    chk("bp_hold2_data", data_out, 16'hCAFE);
    out_ready = 1'b1;
    tick();
    chk("bp_drained", valid_out, 0);

    // Contention, last grant was ch1 so ch0 leads
    i0 = 1'b0; i1 = 1'b0; n_words = 0;
    valid_in0 = 1'b1; data_in0 = 8'h11;
    valid_in1 = 1'b1; data_in1 = 8'h33;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk("ct_exclusive", {31'd0, ready_in0 & ready_in1}, 0);
      hs0 = valid_in0 && ready_in0;
      hs1 = valid_in1 && ready_in1;
      tick();
      if (hs0) begin i0 = ~i0; data_in0 = i0 ? 8'h22 : 8'h11; end
      if (hs1) begin i1 = ~i1; data_in1 = i1 ? 8'h44 : 8'h33; end
      if (valid_out && n_words < 8) begin
        words[n_words] = {ch_out, data_out};
        n_words++;
      end
    end
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    chk("ct_count", n_words, 4);
    chk("ct_w0", {15'd0, words[0]}, {15'd0, 1'b0, 16'h1122});
    chk("ct_w1", {15'd0, words[1]}, {15'd0, 1'b1, 16'h3344});
    chk("ct_w2", {15'd0, words[2]}, {15'd0, 1'b0, 16'h1122});
    chk("ct_w3", {15'd0, words[3]}, {15'd0, 1'b1, 16'h3344});
    tick();
    chk("ct_drained", valid_out, 0);

    // Timeout: lone first byte on ch0
    valid_in0 = 1'b1; data_in0 = 8'h77;
    tick();
    tick();
    valid_in0 = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    chk("to_no_drop_early", drop_err, 0);
    tick();
    chk("to_drop_err", drop_err, 1);
    chk("to_drop_ch", drop_ch, 0);
    chk("to_no_valid", valid_out, 0);
    tick();
    chk("to_pulse_end", drop_err, 0);
    chk("to_idle_ready0", ready_in0, 0);
    pair(1'b0, 8'h12, 8'h34);
    chk("to_after_data", data_out, 16'h1234);
    chk("to_after_ch", ch_out, 0);
    tick();

    // Reset mid-pair with a word pending
    out_ready = 1'b0;
    pair(1'b0, 8'hAB, 8'hCD);
    chk("rm_pending", valid_out, 1);
    valid_in0 = 1'b1; data_in0 = 8'h55;
    tick();
    tick();
    valid_in0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rm_valid_out", valid_out, 0);
    chk("rm_data_out", data_out, 0);
    chk("rm_ch_out", ch_out, 0);
    chk("rm_drop_err", drop_err, 0);
    chk("rm_drop_ch", drop_ch, 0);
    valid_in0 = 1'b1; data_in0 = 8'h5A;
    valid_in1 = 1'b1; data_in1 = 8'hA5;
    tick();
    chk("rm_first_grant0", ready_in0, 1);
    chk("rm_first_grant1", ready_in1, 0);
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    tick();
    chk("rm_no_drop", drop_err, 0);

    // Grant withdrawal on ch1, ch0 then served
    valid_in1 = 1'b1; data_in1 = 8'h99;
    tick();
    chk("wd_hi_ready1", ready_in1, 1);
    valid_in1 = 1'b0;
    valid_in0 = 1'b1; data_in0 = 8'h42;
    #1;
    chk("wd_hi_ready0", ready_in0, 0);
    tick();
    chk("wd_idle_ready0", ready_in0, 0);
    chk("wd_idle_ready1", ready_in1, 0);
    chk("wd_no_output", valid_out, 0);
    tick();
    chk("wd_ch0_granted", ready_in0, 1);
    tick();
    data_in0 = 8'h43;
    tick();
    valid_in0 = 1'b0;
    chk("wd_valid", valid_out, 1);
    chk("wd_data", data_out, 16'h4243);
    chk("wd_ch", ch_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
